// File: rtl/rom_pkg.sv
// Shared types and helpers for the ROM burst controller.
//   rom_burst_state_t : sequencer state encoding (IDLE, STREAM, DONE)
//   onehot_valid()    : 1 when exactly one bit of the vector is set
//   onehot_to_bin()   : index of the set bit of a one-hot vector
// Both helpers take a fixed-width vector of MAX_DEPTH bits. Callers
// zero-extend narrower vectors, so DEPTH must not exceed MAX_DEPTH.
package rom_pkg;

    localparam int MAX_DEPTH = 64;
    localparam int MAX_AW    = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } rom_burst_state_t;

    typedef logic [MAX_DEPTH-1:0] onehot_vec_t;

    function automatic logic onehot_valid(input onehot_vec_t vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (vec[i]) cnt++;
        end
        return (cnt == 1);
    endfunction

    // OR-ing the indices of all set bits gives the index itself for a
    // one-hot input; the result is meaningless otherwise and is gated by
    // onehot_valid() at the call site.
    function automatic logic [MAX_AW-1:0] onehot_to_bin(input onehot_vec_t vec);
        logic [MAX_AW-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (vec[i]) b = b | MAX_AW'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rom_onehot_dec.sv
// One-hot to binary address decoder (purely combinational).
//   onehot : DEPTH-bit one-hot base address
//   bin    : binary index of the set bit
//   valid  : 1 when onehot has exactly one bit set
module rom_onehot_dec
    import rom_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  onehot,
    output logic [ADDR_W-1:0] bin,
    output logic              valid
);

    onehot_vec_t vec;

    always_comb begin
        vec              = '0;
        vec[DEPTH-1:0]   = onehot;
        valid            = onehot_valid(vec);
        bin              = ADDR_W'(onehot_to_bin(vec));
    end

endmodule

// File: rtl/rom_burst_ctrl.sv
// ROM burst read controller. A start command gives a base address and a
// word count; consecutive ROM words are streamed over valid/ready, with
// the address wrapping at DEPTH.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : command strobe, sampled only in IDLE
//   start_addr  : base address, one-hot (DEPTH bits) or binary (ADDR_W bits)
//   len         : word count, legal 1..DEPTH
//   busy        : high in STREAM and DONE
//   dout        : ROM word, 0 whenever dout_valid is low
//   dout_valid  : dout holds a burst word
//   dout_ready  : consumer accepts dout this cycle
//   done        : one-cycle pulse after the last word is accepted
//   err         : one-cycle pulse when a command is rejected
//
// state  | meaning
// IDLE   | waiting for start; rejects illegal commands with err
// STREAM | presenting ROM[ptr]; advances on each accepted word
// DONE   | one cycle with done=1 after the final transfer
module rom_burst_ctrl
    import rom_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int ONEHOT_ADDR = 1,
    parameter logic [DEPTH*DATA_W-1:0] INIT =
        {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [((ONEHOT_ADDR != 0) ? DEPTH : ADDR_W)-1:0] start_addr,
    input  logic [ADDR_W:0]                              len,
    output logic                                         busy,
    output logic [DATA_W-1:0]                            dout,
    output logic                                         dout_valid,
    input  logic                                         dout_ready,
    output logic                                         done,
    output logic                                         err
);

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = INIT[i*DATA_W +: DATA_W];
    end

    logic [ADDR_W-1:0] base_bin;
    logic              addr_ok;

    if (ONEHOT_ADDR != 0) begin : g_onehot
        rom_onehot_dec #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_dec (
            .onehot (start_addr),
            .bin    (base_bin),
            .valid  (addr_ok)
        );
    end else begin : g_bin
        // A binary address past DEPTH-1 (possible when DEPTH is not a power
        // of two) is folded back into range; it is always below 2*DEPTH,
        // so one subtraction suffices.
        logic [ADDR_W:0] addr_ext;
        assign addr_ext = {1'b0, start_addr};
        assign base_bin = (addr_ext >= LEN_MAX) ? ADDR_W'(addr_ext - LEN_MAX)
                                                : start_addr;
        assign addr_ok  = 1'b1;
    end

    logic              cmd_ok;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W:0]   remaining;
    rom_burst_state_t  state;

    assign cmd_ok   = addr_ok && (len != '0) && (len <= LEN_MAX);
    assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ptr        <= '0;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cmd_ok) begin
                            state      <= STREAM;
                            busy       <= 1'b1;
                            dout_valid <= 1'b1;
                            dout       <= rom[base_bin];
                            ptr        <= base_bin;
                            remaining  <= len;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (dout_valid && dout_ready) begin
                        if (remaining > (ADDR_W + 1)'(1)) begin
                            ptr       <= ptr_next;
                            dout      <= rom[ptr_next];
                            remaining <= remaining - 1'b1;
                        end else begin
                            state      <= DONE;
                            dout_valid <= 1'b0;
                            dout       <= '0;
                            done       <= 1'b1;
                            remaining  <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    dout_valid <= 1'b0;
                    dout       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_ctrl.sv
module tb_rom_burst_ctrl;

    logic clk;
    logic rst;

    // default instance: one-hot addressing, DEPTH=8, DATA_W=8
    logic        start0;
    logic [7:0]  sa0;
    logic [3:0]  len0;
    logic        busy0;
    logic [7:0]  dout0;
    logic        dv0;
    logic        rdy0;
    logic        done0;
    logic        err0;

    // binary instance: DEPTH=5, DATA_W=16
    logic        start1;
    logic [2:0]  sa1;
    logic [3:0]  len1;
    logic        busy1;
    logic [15:0] dout1;
    logic        dv1;
    logic        rdy1;
    logic        done1;
    logic        err1;

    int n_checks;
    int n_fail;
    int done_cnt0;
    int err_cnt0;
    int done_cnt1;
    int err_cnt1;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    rom_burst_ctrl u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .start_addr (sa0),
        .len        (len0),
        .busy       (busy0),
        .dout       (dout0),
        .dout_valid (dv0),
        .dout_ready (rdy0),
        .done       (done0),
        .err        (err0)
    );

    rom_burst_ctrl #(
        .DATA_W      (16),
        .DEPTH       (5),
        .ONEHOT_ADDR (0),
        .INIT        ({16'h5005, 16'h4004, 16'h3003, 16'h2002, 16'h1001})
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .start_addr (sa1),
        .len        (len1),
        .busy       (busy1),
        .dout       (dout1),
        .dout_valid (dv1),
        .dout_ready (rdy1),
        .done       (done1),
        .err        (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitors: a word is consumed when valid && ready at the next edge
    always @(negedge clk) begin
        if (!rst) begin
            if (dv0 && rdy0) begin
                if (q0.size() == 0) chk("dut0_unexpected_word", {24'h0, dout0}, 32'hffff_ffff);
                else chk("dut0_word", {24'h0, dout0}, q0.pop_front());
            end
            if (!dv0) chk("dut0_dout_zero", {24'h0, dout0}, 32'h0);
            if (done0) done_cnt0++;
            if (err0)  err_cnt0++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (dv1 && rdy1) begin
                if (q1.size() == 0) chk("dut1_unexpected_word", {16'h0, dout1}, 32'hffff_ffff);
                else chk("dut1_word", {16'h0, dout1}, q1.pop_front());
            end
            if (!dv1) chk("dut1_dout_zero", {16'h0, dout1}, 32'h0);
            if (done1) done_cnt1++;
            if (err1)  err_cnt1++;
        end
    end

    // all stimulus tasks start and end at posedge+1
    task automatic cmd0(input logic [7:0] a, input logic [3:0] l);
        start0 = 1'b1;
        sa0    = a;
        len0   = l;
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle0(input int budget);
        int n;
        n = 0;
        while (busy0 && n < budget) begin
            step();
            n++;
        end
        chk("dut0_idle_timeout", {31'h0, busy0}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_before;
        int busy_cycles;
        logic [7:0] ill_addr [3];
        logic [3:0] ill_len  [3];

        n_checks = 0; n_fail = 0;
        done_cnt0 = 0; err_cnt0 = 0; done_cnt1 = 0; err_cnt1 = 0;
        rst = 1'b1;
        start0 = 1'b0; sa0 = '0; len0 = '0; rdy0 = 1'b0;
        start1 = 1'b0; sa1 = '0; len1 = '0; rdy1 = 1'b0;

        // reset state
        #12;
        chk("rst_busy0", {31'h0, busy0}, 0);
        chk("rst_dv0",   {31'h0, dv0},   0);
        chk("rst_dout0", {24'h0, dout0}, 0);
        chk("rst_done0", {31'h0, done0}, 0);
        chk("rst_err0",  {31'h0, err0},  0);
        chk("rst_busy1", {31'h0, busy1}, 0);
        chk("rst_dv1",   {31'h0, dv1},   0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // reset mid-burst
        rdy0 = 1'b0;
        cmd0(8'h04, 4'd3);
        chk("midrst_first_valid", {31'h0, dv0}, 1);
        chk("midrst_first_word",  {24'h0, dout0}, 32'h33);
        chk("midrst_busy",        {31'h0, busy0}, 1);
        step();
        chk("midrst_hold_word",   {24'h0, dout0}, 32'h33);
        d_before = done_cnt0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_async_busy", {31'h0, busy0}, 0);
        chk("midrst_async_dv",   {31'h0, dv0},   0);
        chk("midrst_async_dout", {24'h0, dout0}, 0);
        chk("midrst_async_done", {31'h0, done0}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(); step();
        chk("midrst_no_done", done_cnt0, d_before);
        chk("midrst_idle",    {31'h0, busy0}, 0);

        // basic burst, full throughput
        rdy0 = 1'b1;
        q0.push_back(32'h33); q0.push_back(32'h44); q0.push_back(32'h55);
        d_before = done_cnt0;
        cmd0(8'h04, 4'd3);
        busy_cycles = 0;
        chk("basic_w0", {24'h0, dout0}, 32'h33);
        if (busy0) busy_cycles++;
        step();
        chk("basic_w1", {24'h0, dout0}, 32'h44);
        if (busy0) busy_cycles++;
        step();
        chk("basic_w2", {24'h0, dout0}, 32'h55);
        if (busy0) busy_cycles++;
        step();
        chk("basic_done_pulse", {31'h0, done0}, 1);
        chk("basic_done_dv",    {31'h0, dv0}, 0);
        if (busy0) busy_cycles++;
        step();
        chk("basic_done_low", {31'h0, done0}, 0);
        if (busy0) busy_cycles++;
        chk("basic_busy_cycles", busy_cycles, 4);
        chk("basic_done_count", done_cnt0 - d_before, 1);

        // address wrap
        q0.push_back(32'h77); q0.push_back(32'h88);
        q0.push_back(32'h11); q0.push_back(32'h22);
        cmd0(8'h40, 4'd4);
        wait_idle0(20);
        chk("wrap_drained", q0.size(), 0);

        // backpressure
        step();
        rdy0 = 1'b0;
        q0.push_back(32'h11); q0.push_back(32'h22);
        d_before = done_cnt0;
        cmd0(8'h01, 4'd2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", {31'h0, dv0}, 1);
            chk("bp_hold_word",  {24'h0, dout0}, 32'h11);
            if (i < 2) step();
        end
        @(negedge clk);
        rdy0 = 1'b1;
        @(posedge clk); #1;
        wait_idle0(20);
        chk("bp_done_once", done_cnt0 - d_before, 1);
        chk("bp_drained",   q0.size(), 0);

        // illegal commands
        ill_addr[0] = 8'h06; ill_len[0] = 4'd1;
        ill_addr[1] = 8'h01; ill_len[1] = 4'd0;
        ill_addr[2] = 8'h01; ill_len[2] = 4'd9;
        step();
        for (int i = 0; i < 3; i++) begin
            cmd0(ill_addr[i], ill_len[i]);
            chk("ill_err_pulse", {31'h0, err0},  1);
            chk("ill_busy",      {31'h0, busy0}, 0);
            chk("ill_dv",        {31'h0, dv0},   0);
            step();
            chk("ill_err_low",   {31'h0, err0},  0);
            chk("ill_busy_after",{31'h0, busy0}, 0);
        end
        chk("ill_err_count", err_cnt0, 3);

        // binary mode DEPTH=5, start ignored mid-burst and in DONE
        rdy1 = 1'b1;
        q1.push_back(32'h4004); q1.push_back(32'h5005); q1.push_back(32'h1001);
        q1.push_back(32'h2002); q1.push_back(32'h3003);
        start1 = 1'b1; sa1 = 3'd3; len1 = 4'd5;
        step();                              // E0 accepted
        start1 = 1'b0;
        chk("bin_first_word", {16'h0, dout1}, 32'h4004);
        step();                              // E1
        step();                              // E2
        start1 = 1'b1; sa1 = 3'd0; len1 = 4'd1;
        step();                              // E3 sampled in STREAM
        start1 = 1'b0;
        chk("bin_midburst_no_err", {31'h0, err1}, 0);
        step();                              // E4
        step();                              // E5 -> DONE
        chk("bin_done_pulse", {31'h0, done1}, 1);
        chk("bin_done_busy",  {31'h0, busy1}, 1);
        start1 = 1'b1;
        step();                              // E6 sampled in DONE
        start1 = 1'b0;
        chk("bin_done_start_no_err", {31'h0, err1}, 0);
        chk("bin_idle_after_done",   {31'h0, busy1}, 0);
        step();                              // E7
        chk("bin_still_idle", {31'h0, busy1}, 0);
        chk("bin_no_err",     {31'h0, err1},  0);
        step();

        chk("final_q0_empty",  q0.size(), 0);
        chk("final_q1_empty",  q1.size(), 0);
        chk("final_done0_cnt", done_cnt0, 3);
        chk("final_err0_cnt",  err_cnt0, 3);
        chk("final_done1_cnt", done_cnt1, 1);
        chk("final_err1_cnt",  err_cnt1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_burst_ctrl.md
Name: rom_burst_ctrl

Overview:
Parametrised, synthesizable ROM read controller with a burst sequencer. A start command carries a base address (one-hot or binary, selected by parameter) and a word count. The block streams consecutive ROM words out over a valid/ready interface, wrapping the address at DEPTH. It serves as the constant-table source feeding downstream datapath blocks, and reports completion and illegal commands.

Parameters:
DATA_W, 8, ROM word width in bits
DEPTH, 8, number of ROM words (>=2)
ADDR_W, $clog2(DEPTH), binary address width (derived; not overridden)
ONEHOT_ADDR, 1, 1 = start_addr is one-hot (DEPTH bits); 0 = start_addr is binary (ADDR_W bits)
INIT, {8'h88,8'h77,8'h66,8'h55,8'h44,8'h33,8'h22,8'h11}, packed DEPTH*DATA_W contents; word i = INIT[i*DATA_W +: DATA_W]

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
start_addr  in  ONEHOT_ADDR ? DEPTH : ADDR_W  burst base address
len  in  ADDR_W+1  words to read; legal range 1..DEPTH
busy  out  1  high while a burst is in STREAM or DONE
dout  out  DATA_W  ROM word; 0 whenever dout_valid=0
dout_valid  out  1  dout holds a burst word
dout_ready  in  1  consumer accepts dout this cycle
done  out  1  one-cycle pulse after the last word is accepted
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset, asynchronous: state=IDLE; busy, dout_valid, done and err = 0; dout=0; pointer and remaining counters = 0.
- FSM states: IDLE, STREAM, DONE.
- IDLE with start=1:
  - Command is illegal if len==0, len>DEPTH, or (ONEHOT_ADDR and start_addr is not exactly one-hot).
  - Illegal command: err=1 next cycle; FSM stays IDLE; no data is produced.
  - Legal command: decode the base address. Next cycle: STREAM, busy=1, dout_valid=1, dout=ROM[base], remaining=len.
- Latency: first word is valid one cycle after start is accepted.
- STREAM handshake:
  - A word transfers when dout_valid and dout_ready are both high.
  - While dout_ready=0, dout and dout_valid hold stable with no change.
  - On a transfer with remaining>1: pointer advances and the next word is presented the following cycle, with no bubble. At full throughput this is 1 word/cycle.
  - On a transfer with remaining==1: go to DONE; dout_valid=0 and dout=0 next cycle.
- Address wrap: pointer goes DEPTH-1 -> 0, including non-power-of-two DEPTH.
- DONE: lasts exactly one cycle with done=1 and busy=1, then IDLE. start asserted in DONE is ignored (no err).
- start while busy (STREAM or DONE): ignored, no err; the current burst is unaffected.
- Back-to-back bursts: minimum spacing from last transfer to the next accepted start is 2 cycles (DONE, then IDLE).
- rst asserted mid-burst: burst aborts immediately and all outputs return to reset values; no done pulse.
- The ROM is a constant array built from INIT. Reads come combinationally from the pointer into the registered dout. No initial blocks or procedural ROM assignment.

Decomposition:
- Package rom_pkg holds:
  - typedef enum logic [1:0] {IDLE, STREAM, DONE} rom_burst_state_t
  - function onehot_valid(vec) (exactly one bit set)
  - function onehot_to_bin(vec)
- Sub-module rom_onehot_dec (param DEPTH): in onehot[DEPTH], out bin[ADDR_W], out valid. Purely combinational. Instantiated only when ONEHOT_ADDR=1; the binary path bypasses it with generate.
- Sequencer, counters and ROM array stay in rom_burst_ctrl.

Test Plan:
- Reset mid-burst: defaults; start_addr=8'h04, len=3, dout_ready=0, rst pulsed during STREAM -> outputs return to 0 asynchronously, FSM IDLE, no done; a new start after reset works.
- Basic burst: defaults; start_addr=8'h04, len=3, dout_ready=1 -> dout 0x33,0x44,0x55 on 3 consecutive cycles starting 1 cycle after start; done pulses the following cycle; busy high for 4 cycles.
- Wrap: start_addr=8'h40, len=4 -> 0x77,0x88,0x11,0x22.
- Backpressure: start_addr=8'h01, len=2, dout_ready low for 3 cycles -> dout holds 0x11 with valid=1 for 3 cycles, then 0x11,0x22 transfer; done once.
- Illegal commands: start_addr=8'h06 (len=1), then len=0, then len=9 -> err pulses for one cycle each; busy and dout_valid stay 0.
- Binary mode, DEPTH=5, DATA_W=16: start_addr=3, len=5 -> words 3,4,0,1,2 from INIT; a start asserted mid-burst and in DONE is ignored, with no err.
